// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, clock glitch filter, frame checker
// with inter-bit timeout, and a first-word fall-through receive FIFO.
module ps2_rx_fifo #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ps2c,
  input  logic                        ps2d,
  input  logic                        rx_en,
  input  logic                        rd_en,
  output logic [7:0]                  dout,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        rx_idle,
  output logic                        frame_err_tick,
  output logic                        parity_err_tick,
  output logic                        timeout_tick,
  output logic                        overflow_tick
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYC);
  localparam logic [AW:0]   FULL_VAL    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  logic                  r_c_meta, r_c_sync, r_d_meta, r_d_sync;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_fclk;
  state_e                r_state;
  logic [9:0]            r_shift;
  logic [3:0]            r_nbits;
  logic [TW-1:0]         r_timer;
  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [AW:0]           r_count;

  logic                  w_fclk_next, w_fall;
  state_e                w_state_next;
  logic [9:0]            w_shift_next;
  logic [3:0]            w_nbits_next;
  logic [TW-1:0]         w_timer_next;
  logic                  w_frame_err, w_parity_err, w_timeout, w_good;
  logic                  w_full, w_push, w_pop;

  // Filtered clock only moves when the whole window agrees; anything shorter is a glitch.
  always_comb begin
    w_fclk_next = r_fclk;
    if (&r_filt)       w_fclk_next = 1'b1;
    else if (~|r_filt) w_fclk_next = 1'b0;
  end

  assign w_fall = r_fclk & ~w_fclk_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c_meta <= 1'b1;
      r_c_sync <= 1'b1;
      r_d_meta <= 1'b1;
      r_d_sync <= 1'b1;
      r_filt   <= '1;
      r_fclk   <= 1'b1;
    end else begin
      r_c_meta <= ps2c;
      r_c_sync <= r_c_meta;
      r_d_meta <= ps2d;
      r_d_sync <= r_d_meta;
      r_filt   <= {r_filt[FILTER_LEN-2:0], r_c_sync};
      r_fclk   <= w_fclk_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_nbits_next = r_nbits;
    w_timer_next = r_timer;
    w_frame_err  = 1'b0;
    w_parity_err = 1'b0;
    w_timeout    = 1'b0;
    w_good       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_fall && rx_en) begin
          if (r_d_sync) begin
            w_frame_err = 1'b1;
          end else begin
            w_nbits_next = '0;
            w_timer_next = '0;
            w_state_next = StShift;
          end
        end
      end
      StShift: begin
        if (w_fall) begin
          w_shift_next = {r_d_sync, r_shift[9:1]};
          w_timer_next = '0;
          if (r_nbits == 4'd9) w_state_next = StCheck;
          else                 w_nbits_next = r_nbits + 4'd1;
        end else if (r_timer == TIMEOUT_VAL) begin
          w_timeout    = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      StCheck: begin
        // r_shift = {stop, parity, data[7:0]}
        w_state_next = StIdle;
        if (!r_shift[9])          w_frame_err  = 1'b1;
        else if (!(^r_shift[8:0])) w_parity_err = 1'b1;
        else                      w_good       = 1'b1;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_nbits <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_nbits <= w_nbits_next;
      r_timer <= w_timer_next;
    end
  end

  // A full FIFO still accepts a push when the consumer pops in the same cycle.
  assign w_full = (r_count == FULL_VAL);
  assign w_pop  = rd_en & ~empty & ~reset;
  assign w_push = w_good & (~w_full | rd_en) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_shift[7:0];
  end

  assign empty           = (r_count == '0);
  assign count           = r_count;
  assign dout            = empty ? 8'h00 : r_mem[r_rptr];
  assign rx_idle         = (r_state == StIdle);
  assign frame_err_tick  = w_frame_err & ~reset;
  assign parity_err_tick = w_parity_err & ~reset;
  assign timeout_tick    = w_timeout & ~reset;
  assign overflow_tick   = w_good & w_full & ~rd_en & ~reset;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: table-driven frames, hand-written corner cases,
// and randomized frames checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int unsigned FILT  = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TOUT  = 1000;
  localparam int          HALF  = 20;

  logic       clk = 1'b0;
  logic       reset, ps2c, ps2d, rx_en, rd_en;
  logic [7:0] dout;
  logic       empty, rx_idle;
  logic [2:0] count;
  logic       frame_err_tick, parity_err_tick, timeout_tick, overflow_tick;

  ps2_rx_fifo #(
    .FILTER_LEN (FILT),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ps2c           (ps2c),
    .ps2d           (ps2d),
    .rx_en          (rx_en),
    .rd_en          (rd_en),
    .dout           (dout),
    .empty          (empty),
    .count          (count),
    .rx_idle        (rx_idle),
    .frame_err_tick (frame_err_tick),
    .parity_err_tick(parity_err_tick),
    .timeout_tick   (timeout_tick),
    .overflow_tick  (overflow_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ferr = 0, n_perr = 0, n_to = 0, n_ovf = 0;
  logic [7:0] q[$];

  // Tick pulses are counted once per cycle high, so a count equals pulse-cycles.
  always @(negedge clk) begin
    if (frame_err_tick)  n_ferr++;
    if (parity_err_tick) n_perr++;
    if (timeout_tick)    n_to++;
    if (overflow_tick)   n_ovf++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_fifo(input string name);
    chk({name, "_count"}, 32'(count), 32'(q.size()));
    chk({name, "_empty"}, 32'(empty), 32'(q.size() == 0));
    chk({name, "_dout"}, 32'(dout), (q.size() == 0) ? 32'h0 : 32'(q[0]));
  endtask

  task automatic chk_ticks(input string name, input int sf, input int sp, input int st,
                           input int so, input int ef, input int ep, input int et,
                           input int eo);
    chk({name, "_ferr"}, n_ferr - sf, ef);
    chk({name, "_perr"}, n_perr - sp, ep);
    chk({name, "_tout"}, n_to - st, et);
    chk({name, "_ovf"}, n_ovf - so, eo);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit par_ok,
                                           input bit stop);
    logic p;
    p = par_ok ? ~(^d) : (^d);
    return {stop, p, d, 1'b0};
  endfunction

  // Bits go out LSB first; the optional rd_en pulse lands in the check cycle of the frame.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch,
                           input int en_off_at, input bit pop_at_check);
    for (int i = 0; i < n; i++) begin
      if (i == en_off_at) rx_en = 1'b0;
      ps2d = bits[i];
      if (glitch) begin
        tick(6); ps2c = 1'b0; tick(3); ps2c = 1'b1; tick(HALF - 9);
      end else begin
        tick(HALF);
      end
      ps2c = 1'b0;
      for (int j = 1; j <= HALF; j++) begin
        tick(1);
        if (pop_at_check && i == n - 1) begin
          if (j == 2 + FILT + 1) rd_en = 1'b1;
          if (j == 2 + FILT + 2) rd_en = 1'b0;
        end
      end
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    tick(HALF);
  endtask

  task automatic do_pop(input string name);
    logic [7:0] tmp;
    if (q.size() > 0) chk({name, "_head"}, 32'(dout), 32'(q[0]));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    if (q.size() > 0) tmp = q.pop_front();
    chk({name, "_cnt"}, 32'(count), 32'(q.size()));
  endtask

  // Reference model: frame outcome from start/parity/stop rules and a bounded queue.
  task automatic run_frame(input string name, input logic [7:0] d, input logic pbit,
                           input logic stop, input bit popc);
    int sf, sp, st, so, ef, ep, eo;
    logic [7:0] tmp;
    sf = n_ferr; sp = n_perr; st = n_to; so = n_ovf;
    ef = 0; ep = 0; eo = 0;
    if (!stop) ef = 1;
    else if ($countones({d, pbit}) % 2 == 0) ep = 1;
    if (popc && q.size() > 0) tmp = q.pop_front();
    if (ef == 0 && ep == 0) begin
      if (q.size() < DEPTH) q.push_back(d);
      else eo = 1;
    end
    send_bits({stop, pbit, d, 1'b0}, 11, 1'b0, -1, popc);
    chk_ticks(name, sf, sp, st, so, ef, ep, 0, eo);
    chk_fifo(name);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         par_ok;
    bit         stop;
    bit         en;
    bit         glitch;
    bit         exp_push;
    bit         exp_ferr;
    bit         exp_perr;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int sf, sp, st, so;
    logic [7:0] d;
    logic pbit, stop;
    int kind;

    vecs[0] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'hF0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; rd_en = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_idle", 32'(rx_idle), 32'h1);
    chk("rst_ticks", 32'(n_ferr + n_perr + n_to + n_ovf), 32'h0);

    // Basic receive and pop of 0x1C
    run_frame("rx1c", 8'h1C, 1'b0, 1'b1, 1'b0);
    do_pop("pop1c");
    chk_fifo("after_pop1c");

    // Bad start bit: only the start fall is sent
    sf = n_ferr; sp = n_perr; st = n_to; so = n_ovf;
    send_bits(11'h001, 1, 1'b0, -1, 1'b0);
    chk_ticks("badstart", sf, sp, st, so, 1, 0, 0, 0);
    chk("badstart_idle", 32'(rx_idle), 32'h1);

    for (int i = 0; i < 6; i++) begin
      sf = n_ferr; sp = n_perr; st = n_to; so = n_ovf;
      rx_en = vecs[i].en;
      send_bits(mk_frame(vecs[i].data, vecs[i].par_ok, vecs[i].stop), 11, vecs[i].glitch,
                -1, 1'b0);
      rx_en = 1'b1;
      if (vecs[i].exp_push) q.push_back(vecs[i].data);
      chk_ticks($sformatf("vec%0d", i), sf, sp, st, so, int'(vecs[i].exp_ferr),
                int'(vecs[i].exp_perr), 0, 0);
      chk_fifo($sformatf("vec%0d", i));
    end
    while (q.size() > 0) do_pop("vec_drain");
    chk_fifo("vec_drained");

    // Inter-bit timeout after start + 4 data bits
    sf = n_ferr; sp = n_perr; st = n_to; so = n_ovf;
    send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 5, 1'b0, -1, 1'b0);
    chk("tout_busy", 32'(rx_idle), 32'h0);
    tick(TOUT + 10);
    chk_ticks("tout", sf, sp, st, so, 0, 0, 1, 0);
    chk("tout_idle", 32'(rx_idle), 32'h1);
    chk_fifo("tout");
    run_frame("after_tout", 8'h5A, 1'b1, 1'b1, 1'b0);
    do_pop("pop5a");

    // rx_en dropped mid-frame still completes the byte
    sf = n_ferr; sp = n_perr; st = n_to; so = n_ovf;
    send_bits(mk_frame(8'h3C, 1'b1, 1'b1), 11, 1'b0, 3, 1'b0);
    rx_en = 1'b1;
    q.push_back(8'h3C);
    chk_ticks("en_mid", sf, sp, st, so, 0, 0, 0, 0);
    chk_fifo("en_mid");
    do_pop("pop3c");

    // Overflow, then push and pop together while full
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      run_frame($sformatf("ovf%0d", i), d, ~(^d), 1'b1, 1'b0);
    end
    chk("ovf_total", 32'(n_ovf), 32'h1);
    do_pop("ovf_pop01");
    run_frame("ovf6", 8'h06, ~(^8'h06), 1'b1, 1'b0);
    run_frame("full_pushpop", 8'h07, ~(^8'h07), 1'b1, 1'b1);
    while (q.size() > 0) do_pop("ovf_drain");
    do_pop("pop_empty");
    chk_fifo("ovf_drained");

    // Randomized frames and pops against the model
    for (int k = 0; k < 20; k++) begin
      d    = 8'($urandom);
      kind = $urandom_range(0, 5);
      stop = (kind != 4);
      pbit = (kind == 5) ? (^d) : ~(^d);
      repeat ($urandom_range(0, 2)) do_pop("rnd_pop");
      run_frame($sformatf("rnd%0d", k), d, pbit, stop, ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a frame
    run_frame("pre_rst", 8'h77, ~(^8'h77), 1'b1, 1'b0);
    send_bits(mk_frame(8'hAA, 1'b1, 1'b1), 7, 1'b0, -1, 1'b0);
    sf = n_ferr; sp = n_perr; st = n_to; so = n_ovf;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    q.delete();
    tick(1);
    chk("mrst_idle", 32'(rx_idle), 32'h1);
    chk_fifo("mrst");
    chk_ticks("mrst", sf, sp, st, so, 0, 0, 0, 0);
    run_frame("after_rst", 8'hAA, ~(^8'hAA), 1'b1, 1'b0);
    do_pop("popaa");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
